// File: rtl/pipelined_adder.sv
// ----------------------------------------------------------------------------
// pipelined_adder
//
// Purpose:
//   WIDTH-bit adder computing {cout, sum} = a + b + cin. The carry chain is
//   split into STAGES chunks of CW = WIDTH/STAGES bits, with one register
//   stage per chunk, so wide adds close timing.
//   - Operand chunks that are not yet consumed travel down the pipe
//     alongside the data (input skew).
//   - Finished sum chunks travel down alongside the data (output deskew).
//   Backpressure uses a single global stall (out_valid & ~out_ready) that
//   freezes every stage.
//
// Parameters:
//   WIDTH   operand/sum width (>= 1, divisible by STAGES)
//   STAGES  pipeline depth, 1..WIDTH; latency is STAGES cycles
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears all state)
//   in_valid   a/b/cin valid this cycle
//   in_ready   block can accept operands (= ~stall, combinational)
//   a, b       unsigned operands
//   cin        carry into bit 0
//   out_valid  sum/cout hold a valid result
//   out_ready  downstream accepts the result this cycle
//   sum        a + b + cin, bits [WIDTH-1:0]
//   cout       carry out of bit WIDTH-1
//   ovf        two's-complement overflow (only with ADDER_OVF_EN)
//
// Optional feature macro: ADDER_OVF_EN adds the ovf output and its register.
// ----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be divisible by STAGES and 1 <= STAGES <= WIDTH");
    end

    // One CW-bit slice of the carry chain: {carry_out, chunk_sum}.
    function automatic logic [CW:0] chunk_add(input logic [CW-1:0] x,
                                              input logic [CW-1:0] y,
                                              input logic          c);
        return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
    endfunction

    // Stage registers, index k = stage number.
    logic             vld_p [STAGES];
    logic             c_p   [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] s_p   [STAGES];

    // What each stage sees at its input this cycle.
    logic             v_src [STAGES];
    logic             c_src [STAGES];
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic [CW:0]      chunk [STAGES];

    logic stall;
    logic accept;

    assign stall    = vld_p[LAST] & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & ~stall;

    // Operands are kept right-aligned: each stage consumes the low CW bits
    // and passes the rest on shifted down, so chunk k always sits at [CW-1:0]
    // of stage k's input. Sum chunks enter at the top and shift down, so after
    // the last stage chunk 0 ends up at bit 0.
    always_comb begin
        v_src[0] = accept;
        c_src[0] = cin;
        a_src[0] = a;
        b_src[0] = b;
        s_src[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = vld_p[k-1];
            c_src[k] = c_p[k-1];
            a_src[k] = a_p[k-1];
            b_src[k] = b_p[k-1];
            s_src[k] = s_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk[k] = chunk_add(a_src[k][CW-1:0], b_src[k][CW-1:0], c_src[k]);
        end
    end

    // Stage k boundary: register chunk k sum/carry plus the skewed operands.
    // Data registers only load when a valid item arrives, so the outputs
    // keep their last values through bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                c_p[k]   <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                s_p[k]   <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= v_src[k];
                if (v_src[k]) begin
                    c_p[k] <= chunk[k][CW];
                    a_p[k] <= a_src[k] >> CW;
                    b_p[k] <= b_src[k] >> CW;
                    s_p[k] <= (s_src[k] >> CW) | (WIDTH'(chunk[k][CW-1:0]) << (WIDTH - CW));
                end
            end
        end
    end

    assign out_valid = vld_p[LAST];
    assign sum       = s_p[LAST];
    assign cout      = c_p[LAST];

`ifdef ADDER_OVF_EN
    // Final stage boundary: the operand MSBs are still present in the top
    // bit of the last chunk, and the sum MSB is the top bit of that chunk's
    // result, so overflow is registered alongside sum/cout.
    logic ovf_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_p <= 1'b0;
        end else if (!stall && v_src[LAST]) begin
            ovf_p <= (a_src[LAST][CW-1] == b_src[LAST][CW-1]) &&
                     (chunk[LAST][CW-1] != a_src[LAST][CW-1]);
        end
    end

    assign ovf = ovf_p;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// ----------------------------------------------------------------------------
// tb_pipelined_adder
//
// Self-checking bench for pipelined_adder. The main instance uses the default
// WIDTH=16/STAGES=4; a second WIDTH=4/STAGES=2 instance is swept over all
// 512 operand combinations. Define ADDER_OVF_EN for both the RTL and this
// bench to exercise the ovf output.
// ----------------------------------------------------------------------------
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [15:0] a, b, sum;
    logic        w_in_valid, w_in_ready, w_cin, w_out_valid, w_out_ready, w_cout;
    logic [3:0]  w_a, w_b, w_sum;
`ifdef ADDER_OVF_EN
    logic        ovf, w_ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    pipelined_adder #(.WIDTH(4), .STAGES(2)) dut_w4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .a         (w_a),
        .b         (w_b),
        .cin       (w_cin),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .sum       (w_sum),
        .cout      (w_cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (w_ovf)
`endif
    );

    task automatic test_reset();
        int cyc = 0;
        @(negedge clk);
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (sum !== 16'h2346 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_setup: out_valid=%b sum=%h, want out_valid=1 sum=2346", out_valid, sum);
        end
        // Assert reset between clock edges and look before the next edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (sum !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_sum: got %h want 0000", sum);
        end
        n_cmp++;
        if (cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cout: got %b want 0", cout);
        end
`ifdef ADDER_OVF_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_carry_chain();
        logic [15:0] va [3] = '{16'h00FF, 16'hFFFF, 16'hFFFF};
        logic [15:0] vb [3] = '{16'h0001, 16'h0000, 16'hFFFF};
        logic        vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] es [3] = '{16'h0100, 16'h0000, 16'hFFFF};
        logic        ec [3] = '{1'b0, 1'b1, 1'b1};
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            in_valid = 1'b1; a = va[v]; b = vb[v]; cin = vc[v]; out_ready = 1'b1;
            for (int n = 1; n <= 4; n++) begin
                @(negedge clk);
                in_valid = 1'b0;
                n_cmp++;
                if (n < 4) begin
                    if (out_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL carry_early_valid v%0d cyc%0d: got %b want 0", v, n, out_valid);
                    end
                end else begin
                    if (out_valid !== 1'b1 || sum !== es[v] || cout !== ec[v]) begin
                        n_fail++;
                        $display("FAIL carry_result v%0d: valid=%b sum=%h cout=%b, want 1 %h %b",
                                 v, out_valid, sum, cout, es[v], ec[v]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_tab [6] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006};
        logic [15:0] exp_q [$];
        logic [15:0] exp_s;
        int sent = 0, got = 0, cyc = 0, stall_left = 0;
        bit stalled = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1 && !stalled) begin
                stalled    = 1'b1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready_stall: got %b want 0", in_ready);
                end
                n_cmp++;
                if (out_valid !== 1'b1 || sum !== 16'h1001) begin
                    n_fail++;
                    $display("FAIL b2b_hold: valid=%b sum=%h, want 1 1001", out_valid, sum);
                end
                stall_left--;
            end else if (out_valid === 1'b1) begin
                exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                n_cmp++;
                if (sum !== exp_s || cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result #%0d: sum=%h cout=%b, want %h 0", got, sum, cout, exp_s);
                end
                got++;
            end
            if (sent < 6) begin
                in_valid = 1'b1;
                a = 16'(sent + 1);
                b = 16'((sent + 1) * 16'h1000);
                cin = 1'b0;
                if (in_ready === 1'b1) begin
                    exp_q.push_back(exp_tab[sent]);
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got !== 6) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results want 6", got);
        end
        repeat (6) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_extra: out_valid=%b want 0", out_valid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'(i + 5); b = 16'h0100; cin = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_pre: out_valid=%b want 0", out_valid);
        end
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_leak: out_valid=%b want 0", out_valid);
            end
        end
        @(negedge clk);
        in_valid = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (n < 4) begin
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_early cyc%0d: out_valid=%b want 0", n, out_valid);
                end
            end else if (out_valid !== 1'b1 || sum !== 16'h0003 || cout !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_result: valid=%b sum=%h cout=%b, want 1 0003 0", out_valid, sum, cout);
            end
        end
    endtask

    task automatic test_sweep_w4();
        logic [5:0] exp_q [$];
        logic [5:0] e;
        int sent = 0, got = 0, cyc = 0;
        int ia, ib, ic, s;
        w_out_ready = 1'b1;
        while (got < 512 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (w_out_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bxxxxxx;
                n_cmp++;
`ifdef ADDER_OVF_EN
                if ({w_ovf, w_cout, w_sum} !== e) begin
`else
                if ({w_cout, w_sum} !== e[4:0]) begin
`endif
                    n_fail++;
                    $display("FAIL sweep #%0d: cout=%b sum=%h, want cout=%b sum=%h (ovf field %b)",
                             got, w_cout, w_sum, e[4], e[3:0], e[5]);
                end
                got++;
            end
            if (sent < 512) begin
                ia = (sent >> 5) & 15;
                ib = (sent >> 1) & 15;
                ic = sent & 1;
                w_in_valid = 1'b1; w_a = 4'(ia); w_b = 4'(ib); w_cin = ic[0];
                if (w_in_ready === 1'b1) begin
                    s = ia + ib + ic;
                    e[4:0] = s[4:0];
                    e[5] = (w_a[3] == w_b[3]) && (s[3] != w_a[3]);
                    exp_q.push_back(e);
                    sent++;
                end
            end else begin
                w_in_valid = 1'b0;
            end
        end
        w_in_valid = 1'b0;
        n_cmp++;
        if (got !== 512 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sweep_count: got %0d results want 512, %0d left", got, exp_q.size());
        end
    endtask

`ifdef ADDER_OVF_EN
    task automatic test_ovf();
        logic [15:0] va [3] = '{16'h7FFF, 16'h8000, 16'h0001};
        logic [15:0] vb [3] = '{16'h0001, 16'hFFFF, 16'h0001};
        logic [15:0] es [3] = '{16'h8000, 16'h7FFF, 16'h0002};
        logic        ec [3] = '{1'b0, 1'b1, 1'b0};
        logic        eo [3] = '{1'b1, 1'b1, 1'b0};
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            in_valid = 1'b1; a = va[v]; b = vb[v]; cin = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || sum !== es[v] || cout !== ec[v] || ovf !== eo[v]) begin
                n_fail++;
                $display("FAIL ovf v%0d: valid=%b sum=%h cout=%b ovf=%b, want 1 %h %b %b",
                         v, out_valid, sum, cout, ovf, es[v], ec[v], eo[v]);
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_carry_chain();
        test_back_to_back();
        test_reset_midflight();
        test_sweep_w4();
`ifdef ADDER_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder that replaces the flat combinational half/full adder cells.
- Computes WIDTH-bit a + b + cin, splitting the carry chain into STAGES registered chunks so wide adds close timing.
- Valid/ready handshake on both sides, with one global stall for backpressure.
- Used as the arithmetic building block for the datapath blocks that follow.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥ 1 and divisible by STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH). Chunk width CW = WIDTH/STAGES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands a/b/cin are valid this cycle.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  sum/cout hold a valid result.
- out_ready  in  1  downstream accepts the result this cycle.
- sum  out  WIDTH  result bits [WIDTH-1:0] of a+b+cin.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow; present only with ADDER_OVF_EN.

Behaviour:
- Reset (async, rst=1):
  - Every stage register, every valid bit and every output are cleared immediately: out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 once rst is low and the pipe is empty.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational; it has no dependency on in_valid.
  - A transaction is accepted on a rising edge with in_valid & in_ready.
- Advance:
  - When stall=0, every stage register shifts one stage per clock.
  - Stage 0 loads the accepted operands, or a bubble (valid=0) if nothing is accepted.
  - When stall=1, all stage registers hold, including out_valid/sum/cout.
- Stage k (0..STAGES-1):
  - Adds chunk k, bits [k*CW+CW-1 : k*CW], of the operands plus the carry registered by stage k-1. Stage 0 uses cin.
  - Registers the chunk sum and the chunk carry.
  - Operand chunks above k are delayed alongside (input skew).
  - Already-computed lower sum chunks are delayed alongside (output deskew).
- Latency and throughput:
  - Latency is exactly STAGES cycles from acceptance to out_valid when not stalled.
  - Each stall cycle adds one cycle of latency.
  - Throughput is 1 result per cycle; results emerge in acceptance order.
  - Nothing is lost or duplicated.
- Output hold: while out_valid=0, sum/cout hold their last values. They carry no meaning and must not be checked.
- Handshake completion: the result is consumed on an edge with out_valid & out_ready. If no new result follows, out_valid falls on that edge.
- STAGES=1: a single registered WIDTH-bit adder with latency 1.
- STAGES=WIDTH: a bit-serial-style skewed pipeline with CW=1.
- Arithmetic:
  - Full (WIDTH+1)-bit result: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
  - Wrap-around is expected behaviour, not an error.
- Simultaneous events:
  - Accept in the same cycle as output handshake: new data enters stage 0 while the tail drains.
  - in_valid high during stall: no acceptance; the source must hold its data.
- Reset mid-operation: all in-flight results are discarded and none emerge after rst is released.
- Parameter violation: elaboration error via generate-time check when WIDTH % STAGES != 0 or STAGES > WIDTH.

Optional Feature:
- Macro: ADDER_OVF_EN.
- Defined:
  - Port ovf exists, registered and aligned with sum and out_valid.
  - ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), treating a, b and sum as two's complement. cin participates through sum.
  - The operand MSBs are carried down the pipe to the final stage.
  - ovf resets to 0 and holds under stall.
- Not defined: no ovf port and no extra registers. All other behaviour is identical.

Test Plan:
- Reset check: assert rst mid-cycle with clk idle, defaults WIDTH=16 STAGES=4 -> out_valid=0, sum=0x0000, cout=0 without a clock edge; in_ready=1 after release.
- Carry crosses chunk boundary: a=0x00FF, b=0x0001, cin=0, out_ready=1 -> exactly 4 cycles later out_valid=1, sum=0x0100, cout=0.
- Full chain propagation: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Backpressure: stream 6 back-to-back ops (a=i, b=0x1000*i) and hold out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 during the stall, outputs frozen, all 6 results in order, none dropped or duplicated.
- Reset mid-flight: accept 3 ops, pulse rst before any emerges -> out_valid stays 0 afterwards; the next op, a=1, b=2, yields sum=0x0003 after 4 cycles.
- Sweep and ovf: WIDTH=4, STAGES=2, all 512 a/b/cin combos streamed against a reference model -> all match. With ADDER_OVF_EN, 0x7FFF+0x0001 -> ovf=1; 0x8000+0xFFFF -> sum=0x7FFF, cout=1, ovf=1; 0x0001+0x0001 -> ovf=0.
